// File: rtl/sdram_wb_bridge.sv
`timescale 1ns/1ps
// Wishbone B4 classic slave in front of the SDRAM controller user port: posted
// full-word writes, reads ordered behind them, and partial writes done as RMW.
//
// state    | meaning
// IDLE     | wait for a window hit; full writes are posted into the FIFO
// DRAIN    | let posted writes reach the controller before a read or RMW
// RD_ISSUE | issue the read pulse, load the read timeout
// RD_WAIT  | wait for read data or timeout; merge bytes for a partial write
// RMW_WR   | issue the merged write
// ACK      | one-cycle Wishbone acknowledge
module sdram_wb_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFE00_0000,
  parameter int          WFIFO_DEPTH = 4,
  parameter int          RD_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [22:0] ctl_addr,
  output logic        ctl_rw,
  output logic [31:0] ctl_wdata,
  output logic        ctl_in_valid,
  input  logic        ctl_busy,
  input  logic [31:0] ctl_rdata,
  input  logic        ctl_out_valid
);
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [PW:0]   PTR_ONE  = (PW+1)'(1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, RD_ISSUE, RD_WAIT, RMW_WR, ACK} state_t;

  state_t        state_q;
  logic          ack_q;
  logic [31:0]   rdat_q;
  logic          ctl_valid_q;
  logic          ctl_rw_q;
  logic [22:0]   ctl_addr_q;
  logic [31:0]   ctl_wdata_q;
  logic [TW-1:0] tmr_q;
  logic          abort_q;
  logic [22:0]   adr_q;
  logic [3:0]    sel_q;
  logic [31:0]   wdat_q;
  logic          we_q;

  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [54:0]   fifo_mem_q [WFIFO_DEPTH];
  logic [54:0]   fifo_head;
  logic          fifo_empty, fifo_full;
  logic          hit, full_wr, push, pop, can_issue, dropped;
  logic [31:0]   merge_d;

  assign hit        = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign full_wr    = wbs_we_i & (wbs_sel_i == 4'hF);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q == {~rd_ptr_q[PW], rd_ptr_q[PW-1:0]});
  assign fifo_head  = fifo_mem_q[rd_ptr_q[PW-1:0]];
  // Busy rises one cycle after an accepted pulse, so never pulse twice in a row.
  assign can_issue  = ~ctl_busy & ~ctl_valid_q;
  assign push       = (state_q == IDLE) & hit & full_wr & ~fifo_full;
  assign pop        = (state_q != RD_ISSUE) & (state_q != RMW_WR) & ~fifo_empty & can_issue;
  assign dropped    = abort_q | ~wbs_cyc_i;
  assign wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_comb begin
    merge_d = ctl_rdata;
    for (int k = 0; k < 4; k++)
      if (sel_q[k]) merge_d[8*k +: 8] = wdat_q[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PW-1:0]] <= {wbs_adr_i[24:2], wbs_dat_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      ctl_valid_q <= 1'b0;
      ctl_rw_q    <= 1'b0;
      ctl_addr_q  <= '0;
      ctl_wdata_q <= '0;
      tmr_q       <= '0;
      abort_q     <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      wdat_q      <= '0;
      we_q        <= 1'b0;
    end else begin
      ack_q       <= 1'b0;
      ctl_valid_q <= 1'b0;
      if (pop) begin
        ctl_valid_q <= 1'b1;
        ctl_rw_q    <= 1'b1;
        ctl_addr_q  <= fifo_head[54:32];
        ctl_wdata_q <= fifo_head[31:0];
      end
      case (state_q)
        IDLE: begin
          if (hit) begin
            if (full_wr) begin
              if (!fifo_full) begin
                state_q <= ACK;
                ack_q   <= 1'b1;
              end
            end else if (wbs_we_i && wbs_sel_i == 4'h0) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end else begin
              adr_q   <= wbs_adr_i[24:2];
              sel_q   <= wbs_sel_i;
              wdat_q  <= wbs_dat_i;
              we_q    <= wbs_we_i;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!wbs_cyc_i) state_q <= IDLE;
          else if (fifo_empty && !ctl_valid_q) state_q <= RD_ISSUE;
        end
        RD_ISSUE: begin
          if (!wbs_cyc_i) begin
            state_q <= IDLE;
          end else if (can_issue) begin
            ctl_valid_q <= 1'b1;
            ctl_rw_q    <= 1'b0;
            ctl_addr_q  <= adr_q;
            tmr_q       <= TMR_LOAD;
            abort_q     <= 1'b0;
            state_q     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // A dropped cycle still waits out the read so its data is not misattributed.
          abort_q <= dropped;
          if (ctl_out_valid) begin
            if (dropped) begin
              state_q <= IDLE;
            end else if (!we_q) begin
              rdat_q  <= ctl_rdata;
              ack_q   <= 1'b1;
              state_q <= ACK;
            end else begin
              wdat_q  <= merge_d;
              state_q <= RMW_WR;
            end
          end else if (tmr_q == '0) begin
            if (dropped) begin
              state_q <= IDLE;
            end else begin
              rdat_q  <= 32'hDEAD_BEEF;
              ack_q   <= 1'b1;
              state_q <= ACK;
            end
          end else begin
            tmr_q <= tmr_q - TMR_ONE;
          end
        end
        RMW_WR: begin
          if (!wbs_cyc_i) begin
            state_q <= IDLE;
          end else if (can_issue) begin
            ctl_valid_q <= 1'b1;
            ctl_rw_q    <= 1'b1;
            ctl_addr_q  <= adr_q;
            ctl_wdata_q <= wdat_q;
            ack_q       <= 1'b1;
            state_q     <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = rdat_q;
  assign ctl_in_valid = ctl_valid_q;
  assign ctl_rw       = ctl_rw_q;
  assign ctl_addr     = ctl_addr_q;
  assign ctl_wdata    = ctl_wdata_q;
endmodule
